// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes, sequencer FSM encoding and datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOTA = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_SHR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Command-driven operand/result sequencer for the 8-bit ALU.
//               Optional result flags enabled by defining ALU_SEQ_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_load,
    input  logic [2:0]       cmd_op,
    input  logic             cmd_dst,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_s,
    input  logic [WIDTH-1:0] alu_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_neg
);

    seq_state_t       r_state;
    seq_state_t       w_next_state;
    logic             r_cmd_ready;
    logic             r_res_valid;
    logic             r_dst;
    logic [2:0]       r_alu_s;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_data;

    logic             w_accept;
    logic             w_wr_en;
    logic             w_wr_dst;
    logic [WIDTH-1:0] w_wr_data;

    assign w_accept = cmd_valid && r_cmd_ready;

    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_wr_dst     = r_dst;
        w_wr_data    = alu_out;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Loads commit the immediate on the accept edge itself.
                    w_next_state = cmd_load ? ST_RESP : ST_EXEC;
                    w_wr_en      = cmd_load;
                    w_wr_dst     = cmd_dst;
                    w_wr_data    = cmd_imm;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_RESP;
                w_wr_en      = 1'b1;
            end
            ST_RESP: begin
                if (res_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Handshake outputs are registered copies of the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_dst       <= 1'b0;
            r_alu_s     <= 3'b000;
            r_a         <= '0;
            r_b         <= '0;
            r_res_data  <= '0;
        end else begin
            r_cmd_ready <= (w_next_state == ST_IDLE);
            r_res_valid <= (w_next_state == ST_RESP);
            if (w_accept) begin
                r_dst <= cmd_dst;
                if (!cmd_load) begin
                    r_alu_s <= cmd_op;
                end
            end
            if (w_wr_en) begin
                if (w_wr_dst) begin
                    r_b <= w_wr_data;
                end else begin
                    r_a <= w_wr_data;
                end
                r_res_data <= w_wr_data;
            end
        end
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic r_zero;
    logic r_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero <= 1'b0;
            r_neg  <= 1'b0;
        end else if (w_wr_en) begin
            r_zero <= (w_wr_data == '0);
            r_neg  <= w_wr_data[WIDTH-1];
        end
    end

    assign res_zero = r_zero;
    assign res_neg  = r_neg;
`else
    assign res_zero = 1'b0;
    assign res_neg  = 1'b0;
`endif

    assign cmd_ready = r_cmd_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_s     = r_alu_s;

endmodule
`default_nettype wire
